// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: operand-select
// codes, the stall FSM state type and the multicycle counter width.
package hazard_pkg;

  // Operand select codes. The EX stage uses MEM=10/WB=01. The decode stage
  // swaps the two codes so that it has its own mux ordering.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The counter only ever holds MC_LAT-2. With MC_LAT capped at 16, four bits are enough.
  localparam int MC_CTR_W = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } stateT;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// Operand match for one source register. It picks the MEM-stage result,
// then the WB-stage result, then the register file. Register 0 never matches.
// The select codes are parameters so that the same block serves both the
// EX-stage muxes and the decode-stage muxes.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int         REG_AW  = 5,
  parameter logic [1:0] MEM_SEL = FWD_MEM,
  parameter logic [1:0] WB_SEL  = FWD_WB
) (
  input  logic [REG_AW-1:0] srcReg,
  input  logic              memEn,
  input  logic [REG_AW-1:0] memRd,
  input  logic              wbEn,
  input  logic [REG_AW-1:0] wbRd,
  output logic [1:0]        sel
);

  // The newer producer (MEM) wins over the older one (WB).
  always_comb begin
    sel = FWD_RF;
    if (memEn && (memRd != '0) && (memRd == srcReg)) begin
      sel = MEM_SEL;
    end else if (wbEn && (wbRd != '0) && (wbRd == srcReg)) begin
      sel = WB_SEL;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard and forwarding controller. It drives the EX and decode
// operand selects, handles load-use and branch-operand stalls, and freezes
// the front of the pipe while a multicycle unit runs. It also counts the
// cycles in which fetch was stalled.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              br_taken,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic              ex_is_load,
  input  logic              ex_is_mc,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wr,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_a_d,
  output logic [1:0]        fwd_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stateT               state;
  logic [MC_CTR_W-1:0] mcCtr;
  logic                mcBusyQ;

  logic [1:0] selExA;
  logic [1:0] selExB;
  logic [1:0] selIdA;
  logic [1:0] selIdB;

  logic memFwdToId;
  logic exRdLive;
  logic memLoadLive;
  logic exRdUsed;
  logic memRdUsed;
  logic loadUse;
  logic branchHaz;
  logic mcStart;
  logic mcStall;

  // A load still in MEM cannot feed decode because its data is not back yet.
  assign memFwdToId = mem_wr && !mem_is_load;

  fwd_sel #(.REG_AW(REG_AW), .MEM_SEL(FWD_MEM), .WB_SEL(FWD_WB)) uFwdExA (
    .srcReg(ex_rs), .memEn(mem_wr), .memRd(mem_rd),
    .wbEn(wb_wr), .wbRd(wb_rd), .sel(selExA)
  );

  fwd_sel #(.REG_AW(REG_AW), .MEM_SEL(FWD_MEM), .WB_SEL(FWD_WB)) uFwdExB (
    .srcReg(ex_rt), .memEn(mem_wr), .memRd(mem_rd),
    .wbEn(wb_wr), .wbRd(wb_rd), .sel(selExB)
  );

  fwd_sel #(.REG_AW(REG_AW), .MEM_SEL(FWD_WB), .WB_SEL(FWD_MEM)) uFwdIdA (
    .srcReg(id_rs), .memEn(memFwdToId), .memRd(mem_rd),
    .wbEn(wb_wr), .wbRd(wb_rd), .sel(selIdA)
  );

  fwd_sel #(.REG_AW(REG_AW), .MEM_SEL(FWD_WB), .WB_SEL(FWD_MEM)) uFwdIdB (
    .srcReg(id_rt), .memEn(memFwdToId), .memRd(mem_rd),
    .wbEn(wb_wr), .wbRd(wb_rd), .sel(selIdB)
  );

  // Work out which decode sources collide with a pending EX or MEM result.
  always_comb begin
    exRdLive    = ex_wr && (ex_rd != '0);
    memLoadLive = mem_is_load && mem_wr && (mem_rd != '0);
    exRdUsed    = (id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd));
    memRdUsed   = (id_use_rs && (id_rs == mem_rd)) || (id_use_rt && (id_rt == mem_rd));
    loadUse     = ex_is_load && exRdLive && exRdUsed;
    branchHaz   = id_is_branch && ((exRdLive && exRdUsed) || (memLoadLive && memRdUsed));
    mcStart     = (state == RUN) && ex_is_mc;
    mcStall     = mcStart || (state == MC_WAIT);
  end

  // Prioritise the control outputs: reset, then multicycle, then hazard, then taken branch.
  always_comb begin
    fwd_a   = FWD_RF;
    fwd_b   = FWD_RF;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    mc_busy = 1'b0;
    if (rst_n) begin
      fwd_a   = selExA;
      fwd_b   = selExB;
      fwd_a_d = selIdA;
      fwd_b_d = selIdB;
      mc_busy = mcBusyQ;
      if (mcStall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (loadUse || branchHaz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_d = br_taken;
      end
    end
  end

  // Multicycle FSM. The first stall cycle happens in RUN, so the wait state
  // lasts MC_LAT-1 cycles, counted down from MC_LAT-2 to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      mcCtr   <= '0;
      mcBusyQ <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_is_mc) begin
            state   <= MC_WAIT;
            mcCtr   <= MC_CTR_W'(MC_LAT - 2);
            mcBusyQ <= 1'b1;
          end
        end
        MC_WAIT: begin
          if (mcCtr == '0) begin
            state   <= RUN;
            mcBusyQ <= 1'b0;
          end else begin
            mcCtr <= mcCtr - 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          mcBusyQ <= 1'b0;
        end
      endcase
    end
  end

  // Count fetch-stall cycles. The count holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Testbench for hazard_forward_ctrl. Stimulus goes through applyStimulus,
// which also pushes the expected response into a scoreboard queue. A monitor
// pops the queue and compares it against the DUT on every falling edge.
module tb_hazard_forward_ctrl;

  localparam int LAT   = 4;
  localparam int CW    = 8;
  localparam int CNTMX = (1 << CW) - 1;

  typedef struct packed {
    logic       rstN;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUseRs;
    logic       idUseRt;
    logic       idIsBranch;
    logic       brTaken;
    logic [4:0] exRs;
    logic [4:0] exRt;
    logic [4:0] exRd;
    logic       exWr;
    logic       exIsLoad;
    logic       exIsMc;
    logic [4:0] memRd;
    logic       memWr;
    logic       memIsLoad;
    logic [4:0] wbRd;
    logic       wbWr;
  } stimT;

  typedef struct packed {
    logic [1:0]    fwdA;
    logic [1:0]    fwdB;
    logic [1:0]    fwdAD;
    logic [1:0]    fwdBD;
    logic          stallF;
    logic          stallD;
    logic          stallE;
    logic          flushD;
    logic          flushE;
    logic          flushM;
    logic          mcBusy;
    logic [CW-1:0] stallCnt;
  } expT;

  logic          clk;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs, id_use_rt, id_is_branch, br_taken;
  logic          ex_wr, ex_is_load, ex_is_mc, mem_wr, mem_is_load, wb_wr;
  logic [1:0]    fwd_a, fwd_b, fwd_a_d, fwd_b_d;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
  logic [CW-1:0] stall_cnt;

  expT expQ[$];
  expT monExp;
  int  compared   = 0;
  int  mismatched = 0;

  // Model state: remaining wait cycles of a multicycle op, and the stall count.
  int  modelMcLeft = 0;
  int  modelCnt    = 0;

  hazard_forward_ctrl #(.REG_AW(5), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .br_taken(br_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wr(ex_wr),
    .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_wr(wb_wr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stimT zeroStim();
    stimT s;
    s = '0;
    s.rstN = 1'b1;
    return s;
  endfunction

  function automatic stimT randStim();
    stimT s;
    s.rstN       = ($urandom_range(0, 39) != 0);
    s.idRs       = 5'($urandom_range(0, 3));
    s.idRt       = 5'($urandom_range(0, 3));
    s.idUseRs    = 1'($urandom_range(0, 1));
    s.idUseRt    = 1'($urandom_range(0, 1));
    s.idIsBranch = ($urandom_range(0, 3) == 0);
    s.brTaken    = 1'($urandom_range(0, 1));
    s.exRs       = 5'($urandom_range(0, 3));
    s.exRt       = 5'($urandom_range(0, 3));
    s.exRd       = 5'($urandom_range(0, 3));
    s.exWr       = 1'($urandom_range(0, 1));
    s.exIsLoad   = ($urandom_range(0, 2) == 0);
    s.exIsMc     = ($urandom_range(0, 11) == 0);
    s.memRd      = 5'($urandom_range(0, 3));
    s.memWr      = 1'($urandom_range(0, 1));
    s.memIsLoad  = ($urandom_range(0, 2) == 0);
    s.wbRd       = 5'($urandom_range(0, 3));
    s.wbWr       = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic logic [1:0] exSel(input logic [4:0] src, input stimT s);
    if (s.memWr && s.memRd != 0 && s.memRd == src) return 2'b10;
    if (s.wbWr && s.wbRd != 0 && s.wbRd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] idSel(input logic [4:0] src, input stimT s);
    if (s.memWr && !s.memIsLoad && s.memRd != 0 && s.memRd == src) return 2'b01;
    if (s.wbWr && s.wbRd != 0 && s.wbRd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit usesReg(input stimT s, input logic [4:0] r);
    return (s.idUseRs && s.idRs == r) || (s.idUseRt && s.idRt == r);
  endfunction

  function automatic expT modelOut(input stimT s);
    expT e;
    bit  busy, hazard;
    e = '0;
    e.stallCnt = CW'(modelCnt);
    if (!s.rstN) return e;
    busy   = (modelMcLeft > 0);
    hazard = (s.exIsLoad && s.exWr && s.exRd != 0 && usesReg(s, s.exRd)) ||
             (s.idIsBranch && ((s.exWr && s.exRd != 0 && usesReg(s, s.exRd)) ||
                               (s.memIsLoad && s.memWr && s.memRd != 0 && usesReg(s, s.memRd))));
    e.fwdA   = exSel(s.exRs, s);
    e.fwdB   = exSel(s.exRt, s);
    e.fwdAD  = idSel(s.idRs, s);
    e.fwdBD  = idSel(s.idRt, s);
    e.mcBusy = busy;
    if (busy || s.exIsMc) begin
      e.stallF = 1; e.stallD = 1; e.stallE = 1; e.flushM = 1;
    end else if (hazard) begin
      e.stallF = 1; e.stallD = 1; e.flushE = 1;
    end else begin
      e.flushD = s.brTaken;
    end
    return e;
  endfunction

  task automatic modelStep(input stimT s, input expT e);
    if (!s.rstN) begin
      modelMcLeft = 0;
      modelCnt    = 0;
    end else begin
      if (modelMcLeft > 0) modelMcLeft--;
      else if (s.exIsMc) modelMcLeft = LAT - 1;
      if (e.stallF && modelCnt < CNTMX) modelCnt++;
    end
  endtask

  task automatic applyStimulus(input stimT s);
    expT e;
    @(posedge clk);
    #1;
    rst_n = s.rstN; id_rs = s.idRs; id_rt = s.idRt;
    id_use_rs = s.idUseRs; id_use_rt = s.idUseRt;
    id_is_branch = s.idIsBranch; br_taken = s.brTaken;
    ex_rs = s.exRs; ex_rt = s.exRt; ex_rd = s.exRd;
    ex_wr = s.exWr; ex_is_load = s.exIsLoad; ex_is_mc = s.exIsMc;
    mem_rd = s.memRd; mem_wr = s.memWr; mem_is_load = s.memIsLoad;
    wb_rd = s.wbRd; wb_wr = s.wbWr;
    e = modelOut(s);
    expQ.push_back(e);
    modelStep(s, e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monExp = expQ.pop_front();
      checkOutput("fwd_a", fwd_a, monExp.fwdA);
      checkOutput("fwd_b", fwd_b, monExp.fwdB);
      checkOutput("fwd_a_d", fwd_a_d, monExp.fwdAD);
      checkOutput("fwd_b_d", fwd_b_d, monExp.fwdBD);
      checkOutput("stall_f", stall_f, monExp.stallF);
      checkOutput("stall_d", stall_d, monExp.stallD);
      checkOutput("stall_e", stall_e, monExp.stallE);
      checkOutput("flush_d", flush_d, monExp.flushD);
      checkOutput("flush_e", flush_e, monExp.flushE);
      checkOutput("flush_m", flush_m, monExp.flushM);
      checkOutput("mc_busy", mc_busy, monExp.mcBusy);
      checkOutput("stall_cnt", stall_cnt, monExp.stallCnt);
    end
  end

  initial begin
    stimT s;
    int   nStall, nBusy;
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_use_rs = 0; id_use_rt = 0; id_is_branch = 0; br_taken = 0;
    ex_wr = 0; ex_is_load = 0; ex_is_mc = 0; mem_wr = 0; mem_is_load = 0; wb_wr = 0;

    s = zeroStim(); s.rstN = 1'b0;
    repeat (3) applyStimulus(s);
    @(negedge clk);
    checkOutput("resetStallCnt", stall_cnt, 0);

    // MEM beats WB for the same register
    s = zeroStim(); s.memWr = 1; s.memRd = 3; s.wbWr = 1; s.wbRd = 3; s.exRs = 3;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("memWinsFwdA", fwd_a, 2);

    // load-use on rt: one stall cycle
    s = zeroStim(); s.exIsLoad = 1; s.exWr = 1; s.exRd = 7; s.idRt = 7; s.idUseRt = 1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("loadUseStallF", stall_f, 1);
    checkOutput("loadUseFlushE", flush_e, 1);
    applyStimulus(zeroStim());
    @(negedge clk);
    checkOutput("loadUseReleased", stall_f, 0);
    checkOutput("loadUseStallCnt", stall_cnt, 1);

    // multicycle op: MC_LAT stall cycles, MC_LAT-1 busy cycles
    nStall = 0; nBusy = 0;
    s = zeroStim(); s.exIsMc = 1;
    applyStimulus(s);
    @(negedge clk);
    nStall += int'(stall_f); nBusy += int'(mc_busy);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(zeroStim());
      @(negedge clk);
      nStall += int'(stall_f); nBusy += int'(mc_busy);
    end
    checkOutput("mcStallCycles", nStall, LAT);
    checkOutput("mcBusyCycles", nBusy, LAT - 1);
    checkOutput("mcStallCnt", stall_cnt, 1 + LAT);

    // branch operand from a load in MEM stalls; from an ALU op it forwards
    s = zeroStim(); s.idIsBranch = 1; s.idRs = 5; s.idUseRs = 1;
    s.memIsLoad = 1; s.memWr = 1; s.memRd = 5;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("branchLoadStall", stall_f, 1);
    s.memIsLoad = 0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("branchAluNoStall", stall_f, 0);
    checkOutput("branchAluFwdAD", fwd_a_d, 1);

    // reset in the second wait cycle aborts the multicycle op
    s = zeroStim(); s.exIsMc = 1;
    applyStimulus(s);
    applyStimulus(zeroStim());
    s = zeroStim(); s.rstN = 0; s.exIsMc = 1; s.memWr = 1; s.memRd = 2; s.exRs = 2;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("rstStallF", stall_f, 0);
    checkOutput("rstFlushM", flush_m, 0);
    checkOutput("rstFwdA", fwd_a, 0);
    applyStimulus(zeroStim());
    @(negedge clk);
    checkOutput("postRstStallF", stall_f, 0);
    checkOutput("postRstBusy", mc_busy, 0);
    checkOutput("postRstStallCnt", stall_cnt, 0);

    // register 0 never stalls
    s = zeroStim(); s.exIsLoad = 1; s.exWr = 1; s.exRd = 0; s.idUseRs = 1; s.idUseRt = 1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("zeroRegNoStall", stall_f, 0);

    // saturation of the stall counter
    s = zeroStim(); s.exIsMc = 1;
    repeat (CNTMX + 5) applyStimulus(s);
    applyStimulus(zeroStim());
    @(negedge clk);
    checkOutput("stallCntSat", stall_cnt, CNTMX);
    s = zeroStim(); s.exIsLoad = 1; s.exWr = 1; s.exRd = 4; s.idRs = 4; s.idUseRs = 1;
    applyStimulus(s);
    applyStimulus(zeroStim());
    @(negedge clk);
    checkOutput("stallCntHold", stall_cnt, CNTMX);

    // randomized traffic against the reference model
    s = zeroStim(); s.rstN = 0;
    repeat (2) applyStimulus(s);
    for (int i = 0; i < 3000; i++) applyStimulus(randStim());

    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
